// File: rtl/matrix_power_seq.sv
// GF(2) matrix exponentiation, right-to-left square-and-multiply.
// One combinational matrix_mul squares the base each cycle. A second one
// forms res*base, which is kept when the current exponent bit is set.

// Combinational NxN GF(2) matrix product: p = a * b, row-major packing.
module matrix_mul #(
  parameter int N = 4
) (
  input  logic [0:N*N-1] a,
  input  logic [0:N*N-1] b,
  output logic [0:N*N-1] p
);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [N-1:0] terms;
      for (genvar gk = 0; gk < N; gk++) begin : g_term
        assign terms[gk] = a[gi*N+gk] & b[gk*N+gj];
      end
      // XOR-reduction replaces the carry-free sum of partial products.
      assign p[gi*N+gj] = ^terms;
    end
  end

endmodule

module matrix_power_seq #(
  parameter int N     = 4,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:N*N-1]   in_mat,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:N*N-1]   out_mat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [0:N*N-1]   res_reg, res_next;
  logic [0:N*N-1]   base_reg, base_next;
  logic [EXP_W-1:0] e_reg, e_next;

  logic [0:N*N-1]   ident;
  logic [0:N*N-1]   prod_res_base;
  logic [0:N*N-1]   prod_base_base;
  logic             accept;

  // Identity matrix: diagonal bits i*N+i set.
  for (genvar gi = 0; gi < N; gi++) begin : g_ident_row
    for (genvar gj = 0; gj < N; gj++) begin : g_ident_col
      assign ident[gi*N+gj] = (gi == gj) ? 1'b1 : 1'b0;
    end
  end

  matrix_mul #(.N(N)) u_mul_res (
    .a (res_reg),
    .b (base_reg),
    .p (prod_res_base)
  );

  matrix_mul #(.N(N)) u_mul_sq (
    .a (base_reg),
    .b (base_reg),
    .p (prod_base_base)
  );

  // Handshake outputs are forced low while rst is high, even before the first reset edge.
  assign in_ready  = (state_reg == IDLE) & ~rst;
  assign out_valid = (state_reg == DONE) & ~rst;
  assign busy      = (state_reg != IDLE) & ~rst;
  assign out_mat   = {(N*N){out_valid}} & res_reg;
  assign accept    = in_valid & in_ready;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      res_reg   <= '0;
      base_reg  <= '0;
      e_reg     <= '0;
    end else begin
      state_reg <= state_next;
      res_reg   <= res_next;
      base_reg  <= base_next;
      e_reg     <= e_next;
    end
  end

  // Next-state and datapath update; registers hold unless a case changes them.
  always_comb begin
    state_next = state_reg;
    res_next   = res_reg;
    base_next  = base_reg;
    e_next     = e_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          res_next   = ident;
          base_next  = in_mat;
          e_next     = in_exp;
          state_next = RUN;
        end
      end
      RUN: begin
        if (e_reg == '0) begin
          state_next = DONE;
        end else begin
          // Both products use the pre-edge res/base of this cycle.
          if (e_reg[0]) begin
            res_next = prod_res_base;
          end
          base_next = prod_base_base;
          e_next    = e_reg >> 1;
        end
      end
      DONE: begin
        // in_valid is ignored here; a new job can only start from IDLE.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_power_seq.sv
// Directed and random checks of matrix_power_seq (N=4, EXP_W=8).
module tb_matrix_power_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] in_mat;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] out_mat;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_power_seq #(.N(4), .EXP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mat    (in_mat),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mat   (out_mat),
    .busy      (busy)
  );

  // Reference GF(2) product, written directly from the definition.
  function automatic logic [0:15] gf_mul(input logic [0:15] x, input logic [0:15] y);
    logic [0:15] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 4; k++) acc = acc ^ (x[i*4+k] & y[k*4+j]);
        r[i*4+j] = acc;
      end
    end
    return r;
  endfunction

  // Reference power by repeated multiplication (not square-and-multiply).
  function automatic logic [0:15] gf_pow(input logic [0:15] a, input int e);
    logic [0:15] r;
    r = 16'h8421;
    for (int n = 0; n < e; n++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic int bit_len(input int e);
    int l;
    l = 0;
    for (int b = 0; b < 8; b++) if (e >= (1 << b)) l = b + 1;
    return l;
  endfunction

  // Drive one job, wait for its result, then consume it. Latency counts the accept cycle as 1.
  task automatic do_job(input logic [0:15] a, input logic [7:0] e,
                        output logic [0:15] r, output int lat, output bit to);
    int guard;
    in_mat = a; in_exp = e; in_valid = 1'b1; guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_mat = ~a; in_exp = ~e;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    to = !out_valid;
    r = out_mat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int guard;
    int seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mat = '0; in_exp = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if ({in_ready, out_valid, busy, out_mat} !== 19'd0) begin
        bad++; $display("FAIL reset_init: rdy=%b vld=%b busy=%b mat=%h, need all 0", in_ready, out_valid, busy, out_mat);
      end
    end
    rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: rdy=%b busy=%b, need 1/0", in_ready, busy);
    end
    // Start a long job, then reset it while in RUN.
    in_mat = 16'h4218; in_exp = 8'd255; in_valid = 1'b1; guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset_busy_run: busy=%b, need 1", busy);
    end
    rst = 1'b1; #1;
    total++;
    if ({in_ready, out_valid, busy, out_mat} !== 19'd0) begin
      bad++; $display("FAIL reset_async_gate: rdy=%b vld=%b busy=%b mat=%h, need all 0", in_ready, out_valid, busy, out_mat);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if ({in_ready, out_valid, busy, out_mat} !== 19'd0) begin
        bad++; $display("FAIL reset_midrun: rdy=%b vld=%b busy=%b mat=%h, need all 0", in_ready, out_valid, busy, out_mat);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_after: rdy=%b busy=%b, need 1/0", in_ready, busy);
    end
    seen_valid = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen_valid++;
      @(posedge clk); #1;
    end
    total++;
    if (seen_valid != 0) begin
      bad++; $display("FAIL reset_discard: out_valid cycles=%0d, need 0", seen_valid);
    end
    $display("reset test complete");
  endtask

  task automatic test_directed();
    logic [0:15] ta [0:7];
    logic [7:0]  te [0:7];
    logic [0:15] tx [0:7];
    int          tl [0:7];
    logic [0:15] r;
    int lat;
    bit to;
    ta = '{16'h4210, 16'h4210, 16'h4210, 16'h4218, 16'h4218, 16'h0000, 16'h0000, 16'h4218};
    te = '{8'd0,     8'd2,     8'd4,     8'd5,     8'd255,   8'd0,     8'd5,     8'd1};
    tx = '{16'h8421, 16'h2100, 16'h0000, 16'h4218, 16'h1842, 16'h8421, 16'h0000, 16'h4218};
    tl = '{2,        4,        5,        5,        10,       2,        5,        3};
    for (int t = 0; t < 8; t++) begin
      do_job(ta[t], te[t], r, lat, to);
      $display("directed A=%h E=%0d -> %h lat=%0d", ta[t], te[t], r, lat);
      total++;
      if (to || r !== tx[t]) begin
        bad++; $display("FAIL directed_result[%0d]: got %h timeout=%b, need %h", t, r, to, tx[t]);
      end
      total++;
      if (lat != tl[t]) begin
        bad++; $display("FAIL directed_latency[%0d]: got %0d, need %0d", t, lat, tl[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    int lat;
    in_mat = 16'h4218; in_exp = 8'd3; in_valid = 1'b1; out_ready = 1'b0; guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat != 4) begin
      bad++; $display("FAIL bp_latency: got %0d, need 4", lat);
    end
    for (int c = 0; c < 6; c++) begin
      total++;
      if (out_valid !== 1'b1 || out_mat !== 16'h1842 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d]: vld=%b mat=%h rdy=%b busy=%b, need 1/1842/0/1", c, out_valid, out_mat, in_ready, busy);
      end
      if (c == 2) begin in_valid = 1'b1; in_mat = 16'hFFFF; in_exp = 8'd1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release: vld=%b rdy=%b busy=%b, need 0/1/0", out_valid, in_ready, busy);
    end
    $display("backpressure job A=4218 E=3 held 6 cycles, released");
  endtask

  task automatic test_back_to_back();
    logic [0:15] ja [0:3];
    logic [7:0]  je [0:3];
    int issued;
    int done;
    bit will_acc;
    bit overlap;
    ja = '{16'h4218, 16'h4210, 16'hA5C3, 16'h4218};
    je = '{8'd3,     8'd2,     8'd7,     8'd0};
    issued = 0; done = 0; overlap = 1'b0;
    in_mat = ja[0]; in_exp = je[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && done < 4; cyc++) begin
      if (out_valid) begin
        if (in_ready) overlap = 1'b1;
        $display("b2b job %0d A=%h E=%0d -> %h", done, ja[done], je[done], out_mat);
        total++;
        if (out_mat !== gf_pow(ja[done], int'(je[done]))) begin
          bad++; $display("FAIL b2b_result[%0d]: got %h, need %h", done, out_mat, gf_pow(ja[done], int'(je[done])));
        end
        done++;
      end
      will_acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (will_acc) begin
        issued++;
        if (issued < 4) begin in_mat = ja[issued]; in_exp = je[issued]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (issued != 4 || done != 4) begin
      bad++; $display("FAIL b2b_count: accepts=%0d results=%0d, need 4/4", issued, done);
    end
    total++;
    if (overlap) begin
      bad++; $display("FAIL b2b_overlap: in_ready high during DONE, need low");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [0:15] a;
    logic [7:0]  e;
    logic [0:15] r;
    logic [0:15] x;
    int lat;
    bit to;
    for (int t = 0; t < 500; t++) begin
      a = 16'($urandom);
      e = 8'($urandom_range(0, 255));
      do_job(a, e, r, lat, to);
      x = gf_pow(a, int'(e));
      $display("random %0d A=%h E=%0d -> %h lat=%0d", t, a, e, r, lat);
      total++;
      if (to || r !== x) begin
        bad++; $display("FAIL random_result[%0d]: got %h timeout=%b, need %h", t, r, to, x);
      end
      total++;
      if (lat != bit_len(int'(e)) + 2) begin
        bad++; $display("FAIL random_latency[%0d]: got %0d, need %0d", t, lat, bit_len(int'(e)) + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
